// File: rtl/ddram_arb.sv
// DDR3 port arbiter/sequencer: CPU single-beat R/W (A) against a read-only burst fetcher (B).
// Build with DDRAM_ARB_STARVE_EN defined to force a B grant after STARVE_MAX back-to-back A grants.
module ddram_arb #(
    parameter int STARVE_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [28:0] a_addr,
    input  logic [63:0] a_din,
    input  logic [7:0]  a_be,
    output logic [63:0] a_dout,
    output logic        a_ack,

    input  logic        b_req,
    input  logic [28:0] b_addr,
    input  logic [7:0]  b_len,
    output logic [63:0] b_dout,
    output logic        b_valid,
    output logic        b_done,

    output logic        DDRAM_CLK,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE
);

    typedef enum logic [2:0] {IDLE, A_WR, A_RD, A_RDW, B_RD, B_RDW, HOLD} state_t;

    state_t     state;
    logic [7:0] beat_cnt;
    logic       starved;
    logic       grant_a;
    logic       grant_b;

    assign DDRAM_CLK = clk;

`ifdef DDRAM_ARB_STARVE_EN
    logic [7:0] starve_cnt;

    assign starved = int'(starve_cnt) >= STARVE_MAX;

    // Counts A grants made while B waits; any idle B request level restarts the count.
    always_ff @(posedge clk) begin
        if (rst || !b_req)
            starve_cnt <= 8'd0;
        else if (state == IDLE && grant_b)
            starve_cnt <= 8'd0;
        else if (state == IDLE && grant_a && starve_cnt != 8'hFF)
            starve_cnt <= starve_cnt + 8'd1;
    end
`else
    // Fixed priority: B is never forced ahead of A.
    assign starved = (STARVE_MAX < 0);
`endif

    assign grant_b = b_req && (!a_req || starved);
    assign grant_a = a_req && !grant_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            beat_cnt       <= 8'd0;
            a_dout         <= 64'd0;
            a_ack          <= 1'b0;
            b_dout         <= 64'd0;
            b_valid        <= 1'b0;
            b_done         <= 1'b0;
            DDRAM_BURSTCNT <= 8'd0;
            DDRAM_ADDR     <= 29'd0;
            DDRAM_RD       <= 1'b0;
            DDRAM_DIN      <= 64'd0;
            DDRAM_BE       <= 8'd0;
            DDRAM_WE       <= 1'b0;
        end else begin
            a_ack   <= 1'b0;
            b_valid <= 1'b0;
            b_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_b) begin
                        DDRAM_ADDR     <= b_addr;
                        DDRAM_BURSTCNT <= b_len;
                        DDRAM_RD       <= (b_len != 8'd0);
                        state          <= B_RD;
                    end else if (grant_a) begin
                        DDRAM_ADDR     <= a_addr;
                        DDRAM_BURSTCNT <= 8'd1;
                        DDRAM_DIN      <= a_din;
                        DDRAM_BE       <= a_be;
                        DDRAM_WE       <= a_we;
                        DDRAM_RD       <= !a_we;
                        state          <= a_we ? A_WR : A_RD;
                    end
                end
                A_WR: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_WE <= 1'b0;
                        a_ack    <= 1'b1;
                        state    <= HOLD;
                    end
                end
                A_RD: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                        state    <= A_RDW;
                    end
                end
                A_RDW: begin
                    if (DDRAM_DOUT_READY) begin
                        a_dout <= DDRAM_DOUT;
                        a_ack  <= 1'b1;
                        state  <= HOLD;
                    end
                end
                B_RD: begin
                    // Zero-length burst completes without touching the DDR port.
                    if (DDRAM_BURSTCNT == 8'd0) begin
                        b_done <= 1'b1;
                        state  <= HOLD;
                    end else if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                        beat_cnt <= DDRAM_BURSTCNT;
                        state    <= B_RDW;
                    end
                end
                B_RDW: begin
                    if (DDRAM_DOUT_READY) begin
                        b_valid  <= 1'b1;
                        b_dout   <= DDRAM_DOUT;
                        beat_cnt <= beat_cnt - 8'd1;
                        if (beat_cnt == 8'd1) begin
                            b_done <= 1'b1;
                            state  <= HOLD;
                        end
                    end
                end
                HOLD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
